// File: rtl/maxpool2x2_engine_pkg.sv
// Shared types and constants for the 2x2 stride-2 max-pooling engine:
// FSM state encoding and the fixed pixel order inside a pooling window.
package maxpool2x2_engine_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_ADDR  = 3'd1;
  localparam logic [STATE_W-1:0] ST_READ  = 3'd2;
  localparam logic [STATE_W-1:0] ST_WRITE = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_ADDR  = ST_ADDR,
    S_READ  = ST_READ,
    S_WRITE = ST_WRITE,
    S_DONE  = ST_DONE
  } state_e;

  // Window order k=0..3: (0,0) (0,1) (1,0) (1,1) as (dy,dx); bit k holds the offset.
  localparam logic [3:0] WIN_DX = 4'b1010;
  localparam logic [3:0] WIN_DY = 4'b1100;

  function automatic logic win_dx(input logic [1:0] k);
    return WIN_DX[k];
  endfunction

  function automatic logic win_dy(input logic [1:0] k);
    return WIN_DY[k];
  endfunction

endpackage

// File: rtl/maxpool2x2_engine_if.sv
// Engine-side view of the stream wrapper: start/done handshake plus the
// input-buffer read port and output-buffer write port.
interface maxpool2x2_engine_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int IN_ADR_WIDTH  = 8,
  parameter int OUT_ADR_WIDTH = 8
);
  logic                     start;
  logic                     done;
  logic [IN_ADR_WIDTH-1:0]  bufferIn_adr;
  logic [DATA_WIDTH-1:0]    bufferIn_data;
  logic [OUT_ADR_WIDTH-1:0] bufferOut_adr;
  logic [DATA_WIDTH-1:0]    bufferOut_data;
  logic                     bufferOut_wr;

  // Wrapper side: owns the buffers and the start pulse.
  modport master (
    output start, bufferIn_data,
    input  done, bufferIn_adr, bufferOut_adr, bufferOut_data, bufferOut_wr
  );

  // Engine side.
  modport slave (
    input  start, bufferIn_data,
    output done, bufferIn_adr, bufferOut_adr, bufferOut_data, bufferOut_wr
  );
endinterface

// File: rtl/maxpool2x2_engine_pool_window_addr_gen.sv
// Window/output counters for the pooling walk: produces the current input
// pixel address, the output index and end-of-window / end-of-map flags.
module pool_window_addr_gen
  import maxpool2x2_engine_pkg::*;
#(
  parameter int IMG_W         = 4,
  parameter int IMG_H         = 4,
  parameter int IN_ADR_WIDTH  = 8,
  parameter int OUT_ADR_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step,
  input  logic                     clear,
  output logic [IN_ADR_WIDTH-1:0]  pix_adr,
  output logic [OUT_ADR_WIDTH-1:0] out_idx,
  output logic                     first_k,
  output logic                     last_k,
  output logic                     last_o
);
  localparam int OW = IMG_W / 2;
  localparam int OH = IMG_H / 2;
  localparam int XW = (OW > 1) ? $clog2(OW) : 1;
  localparam int YW = (OH > 1) ? $clog2(OH) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(OW - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(OH - 1);

  logic [1:0]    k;
  logic [XW-1:0] ox;
  logic [YW-1:0] oy;
  logic          last_x, last_y;
  logic [31:0]   pix_x, pix_y;

  assign first_k = (k == 2'd0);
  assign last_k  = (k == 2'd3);
  assign last_x  = (ox == X_LAST);
  assign last_y  = (oy == Y_LAST);
  assign last_o  = last_x && last_y;

  // k wraps 3->0 on its own; the window position only moves when it does.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      k  <= '0;
      ox <= '0;
      oy <= '0;
    end else if (step) begin
      k <= k + 2'd1;
      if (last_k) begin
        if (last_x) begin
          ox <= '0;
          oy <= last_y ? '0 : oy + YW'(1);
        end else begin
          ox <= ox + XW'(1);
        end
      end
    end
  end

  assign pix_x   = 32'(ox) * 2 + 32'(win_dx(k));
  assign pix_y   = 32'(oy) * 2 + 32'(win_dy(k));
  assign pix_adr = IN_ADR_WIDTH'(pix_y * IMG_W + pix_x);
  assign out_idx = OUT_ADR_WIDTH'(32'(oy) * OW + 32'(ox));

endmodule

// File: rtl/maxpool2x2_engine.sv
// 2x2 stride-2 max-pooling engine with optional ReLU: reads the input map
// from the wrapper buffer, writes pooled results back, then pulses done.
module maxpool2x2_engine
  import maxpool2x2_engine_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int IMG_W         = 4,
  parameter int IMG_H         = 4,
  parameter int IN_ADR_WIDTH  = 8,
  parameter int OUT_ADR_WIDTH = 8,
  parameter int RELU          = 1
) (
  input  logic                clk,
  input  logic                rst,
  maxpool2x2_engine_if.slave  axisif
);
  state_e                   state, state_nxt;
  logic                     gen_step, gen_clear;
  logic [IN_ADR_WIDTH-1:0]  pix_adr;
  logic [OUT_ADR_WIDTH-1:0] out_idx;
  logic                     first_k, last_k, last_o;
  logic [DATA_WIDTH-1:0]    acc;
  logic [DATA_WIDTH-1:0]    result;
  logic                     take;

  pool_window_addr_gen #(
    .IMG_W         (IMG_W),
    .IMG_H         (IMG_H),
    .IN_ADR_WIDTH  (IN_ADR_WIDTH),
    .OUT_ADR_WIDTH (OUT_ADR_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .step    (gen_step),
    .clear   (gen_clear),
    .pix_adr (pix_adr),
    .out_idx (out_idx),
    .first_k (first_k),
    .last_k  (last_k),
    .last_o  (last_o)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Counters advance on the READ of k<3 and on WRITE, which also wraps
  // them to zero after the final window.
  always_comb begin
    state_nxt = state;
    gen_step  = 1'b0;
    gen_clear = 1'b0;
    case (state)
      S_IDLE: begin
        gen_clear = 1'b1;
        if (axisif.start) state_nxt = S_ADDR;
      end
      S_ADDR: state_nxt = S_READ;
      S_READ: begin
        if (last_k) begin
          state_nxt = S_WRITE;
        end else begin
          state_nxt = S_ADDR;
          gen_step  = 1'b1;
        end
      end
      S_WRITE: begin
        gen_step  = 1'b1;
        state_nxt = last_o ? S_DONE : S_ADDR;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strict signed compare: ties keep the earlier pixel.
  assign take = first_k || ($signed(axisif.bufferIn_data) > $signed(acc));

  always_ff @(posedge clk) begin
    if (rst)                          acc <= '0;
    else if (state == S_READ && take) acc <= axisif.bufferIn_data;
  end

  assign result = (RELU != 0 && acc[DATA_WIDTH-1]) ? '0 : acc;

  always_comb begin
    axisif.done           = 1'b0;
    axisif.bufferIn_adr   = '0;
    axisif.bufferOut_wr   = 1'b0;
    axisif.bufferOut_adr  = '0;
    axisif.bufferOut_data = '0;
    case (state)
      S_ADDR, S_READ: axisif.bufferIn_adr = pix_adr;
      S_WRITE: begin
        axisif.bufferOut_wr   = 1'b1;
        axisif.bufferOut_adr  = out_idx;
        axisif.bufferOut_data = result;
      end
      S_DONE:  axisif.done = 1'b1;
      default: ;
    endcase
  end

  a_wr_single: assert property (@(posedge clk) disable iff (rst)
    axisif.bufferOut_wr |=> !axisif.bufferOut_wr);
  a_done_single: assert property (@(posedge clk) disable iff (rst)
    axisif.done |=> !axisif.done);
  a_done_to_idle: assert property (@(posedge clk) disable iff (rst)
    (state == S_DONE) |=> (state == S_IDLE));

endmodule

// File: tb/tb_maxpool2x2_engine.sv
// Bench for maxpool2x2_engine: 4x4 instances with and without ReLU sharing
// one combinational-read buffer, plus a 6x2 instance on a registered-read buffer.
module tb_maxpool2x2_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maxpool2x2_engine_if #(.DATA_WIDTH(32), .IN_ADR_WIDTH(8), .OUT_ADR_WIDTH(8)) a0(), a1(), a2();

  logic [31:0] mem0 [16];
  logic [31:0] mem2 [16];
  logic [31:0] rd2;

  assign a0.start         = start_a;
  assign a1.start         = start_a;
  assign a2.start         = start_b;
  assign a0.bufferIn_data = mem0[a0.bufferIn_adr[3:0]];
  assign a1.bufferIn_data = mem0[a1.bufferIn_adr[3:0]];
  always @(posedge clk) rd2 <= mem2[a2.bufferIn_adr[3:0]];
  assign a2.bufferIn_data = rd2;

  maxpool2x2_engine #(.RELU(1)) u0 (.clk(clk), .rst(rst), .axisif(a0));
  maxpool2x2_engine #(.RELU(0)) u1 (.clk(clk), .rst(rst), .axisif(a1));
  maxpool2x2_engine #(.IMG_W(6), .IMG_H(2), .RELU(1)) u2 (.clk(clk), .rst(rst), .axisif(a2));

  typedef struct packed {
    int          cyc;
    logic [7:0]  adr;
    logic [31:0] data;
  } wr_t;

  wr_t wq0[$], wq1[$], wq2[$];
  int  dq0[$], dq1[$], dq2[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (a0.bufferOut_wr) wq0.push_back(wr_t'{cyc, a0.bufferOut_adr, a0.bufferOut_data});
    if (a1.bufferOut_wr) wq1.push_back(wr_t'{cyc, a1.bufferOut_adr, a1.bufferOut_data});
    if (a2.bufferOut_wr) wq2.push_back(wr_t'{cyc, a2.bufferOut_adr, a2.bufferOut_data});
    if (a0.done) dq0.push_back(cyc);
    if (a1.done) dq1.push_back(cyc);
    if (a2.done) dq2.push_back(cyc);
    if (!rst && !a0.bufferOut_wr) begin
      chk("idle_out_adr", 32'(a0.bufferOut_adr), 32'd0);
      chk("idle_out_data", a0.bufferOut_data, 32'd0);
    end
  end

  // Reference: plain max over each 2x2 block, then optional clamp.
  function automatic logic [31:0] ref_pool(input bit big, input int o, input bit relu);
    int w, ox, oy, a;
    logic signed [31:0] best, p;
    w  = big ? 6 : 4;
    ox = o % (w / 2);
    oy = o / (w / 2);
    best = 0;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        a = (2 * oy + dy) * w + 2 * ox + dx;
        p = big ? mem2[a] : mem0[a];
        if ((dy == 0 && dx == 0) || p > best) best = p;
      end
    if (relu && best < 0) best = 0;
    return best;
  endfunction

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input bit b);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic launch(input bit b, output int t0);
    wq0.delete(); wq1.delete(); wq2.delete();
    dq0.delete(); dq1.delete(); dq2.delete();
    t0 = cyc;
    pulse(b);
  endtask

  task automatic check_run(input int inst, input int t0, input int n, input logic [3:0][31:0] exp);
    wr_t q[$];
    int  d[$];
    goto(t0 + 9 * n + 2);
    case (inst)
      0:       begin q = wq0; d = dq0; end
      1:       begin q = wq1; d = dq1; end
      default: begin q = wq2; d = dq2; end
    endcase
    chk($sformatf("u%0d_nwr", inst), 32'(q.size()), 32'(n));
    for (int i = 0; i < n && i < q.size(); i++) begin
      chk($sformatf("u%0d_wr%0d_cyc", inst, i), 32'(q[i].cyc - t0), 32'(9 + 9 * i));
      chk($sformatf("u%0d_wr%0d_adr", inst, i), 32'(q[i].adr), 32'(i));
      chk($sformatf("u%0d_wr%0d_data", inst, i), q[i].data, exp[i]);
    end
    chk($sformatf("u%0d_ndone", inst), 32'(d.size()), 32'd1);
    if (d.size() > 0) chk($sformatf("u%0d_done_cyc", inst), 32'(d[0] - t0), 32'(9 * n + 1));
  endtask

  typedef struct packed {
    logic [15:0][31:0] pix;
    logic [3:0][31:0]  e_relu;
    logic [3:0][31:0]  e_lin;
  } vec_t;

  vec_t vt[4];
  int   adr6[12] = '{0, 1, 6, 7, 2, 3, 8, 9, 4, 5, 10, 11};

  task automatic load_vec(input int v);
    for (int i = 0; i < 16; i++) mem0[i] = vt[v].pix[i];
  endtask

  initial begin
    int t0, t1;
    logic [3:0][31:0] er, el;

    for (int i = 0; i < 16; i++) begin
      vt[0].pix[i] = 32'(i);
      vt[1].pix[i] = 32'hFFFF_FFFD;
      vt[2].pix[i] = 32'd0;
      vt[3].pix[i] = 32'd4;
      mem0[i] = 32'd0;
      mem2[i] = 32'd0;
    end
    vt[2].pix[0]  = 32'hFFFF_FFFF; vt[2].pix[1]  = 32'h7FFF_FFFF;
    vt[2].pix[4]  = 32'h8000_0000; vt[2].pix[5]  = 32'd2;
    vt[2].pix[2]  = 32'hFFFF_FFFB; vt[2].pix[3]  = 32'hFFFF_FFFE;
    vt[2].pix[6]  = 32'hFFFF_FFF7; vt[2].pix[7]  = 32'hFFFF_FFF9;
    vt[2].pix[10] = 32'h8000_0000; vt[2].pix[11] = 32'h8000_0000;
    vt[2].pix[14] = 32'h8000_0000; vt[2].pix[15] = 32'h8000_0000;
    vt[0].e_relu = {32'd15, 32'd13, 32'd7, 32'd5};
    vt[0].e_lin  = {32'd15, 32'd13, 32'd7, 32'd5};
    vt[1].e_relu = '0;
    vt[1].e_lin  = {4{32'hFFFF_FFFD}};
    vt[2].e_relu = {32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF};
    vt[2].e_lin  = {32'h8000_0000, 32'd0, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
    vt[3].e_relu = {4{32'd4}};
    vt[3].e_lin  = {4{32'd4}};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(a0.done), 32'd0);
    chk("rst_wr", 32'(a0.bufferOut_wr), 32'd0);
    chk("rst_in_adr", 32'(a0.bufferIn_adr), 32'd0);
    chk("rst_out_adr", 32'(a0.bufferOut_adr), 32'd0);
    chk("rst_out_data", a0.bufferOut_data, 32'd0);
    rst = 1'b0;
    goto(cyc + 2);

    for (int v = 0; v < 4; v++) begin
      load_vec(v);
      launch(1'b0, t0);
      check_run(0, t0, 4, vt[v].e_relu);
      check_run(1, t0, 4, vt[v].e_lin);
      goto(cyc + 2);
    end

    // Start re-pulsed mid-run must not disturb the schedule.
    load_vec(0);
    launch(1'b0, t0);
    goto(t0 + 5);
    pulse(1'b0);
    check_run(0, t0, 4, vt[0].e_relu);
    goto(cyc + 2);

    // Reset mid-run, then a fresh run.
    launch(1'b0, t0);
    goto(t0 + 20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_done", 32'(a0.done), 32'd0);
    chk("midrst_wr", 32'(a0.bufferOut_wr), 32'd0);
    chk("midrst_in_adr", 32'(a0.bufferIn_adr), 32'd0);
    chk("midrst_out_adr", 32'(a0.bufferOut_adr), 32'd0);
    chk("midrst_out_data", a0.bufferOut_data, 32'd0);
    rst = 1'b0;
    goto(t0 + 25);
    chk("midrst_nwr", 32'(wq0.size()), 32'd2);
    chk("midrst_nodone", 32'(dq0.size()), 32'd0);
    launch(1'b0, t1);
    check_run(0, t1, 4, vt[0].e_relu);
    check_run(1, t1, 4, vt[0].e_lin);

    // Start during DONE is dropped; start in the following IDLE is taken.
    goto(cyc + 2);
    load_vec(2);
    launch(1'b0, t0);
    goto(t0 + 37);
    pulse(1'b0);
    check_run(0, t0, 4, vt[2].e_relu);
    goto(t0 + 39);
    load_vec(3);
    launch(1'b0, t1);
    check_run(0, t1, 4, vt[3].e_relu);
    check_run(1, t1, 4, vt[3].e_lin);

    for (int r = 0; r < 6; r++) begin
      goto(cyc + 1 + r);
      for (int i = 0; i < 16; i++)
        mem0[i] = (r % 2 == 1) ? $urandom : 32'($urandom_range(0, 8)) - 32'd4;
      for (int o = 0; o < 4; o++) begin
        er[o] = ref_pool(1'b0, o, 1'b1);
        el[o] = ref_pool(1'b0, o, 1'b0);
      end
      launch(1'b0, t0);
      check_run(0, t0, 4, er);
      check_run(1, t0, 4, el);
    end

    // 6x2 map on a registered-read buffer.
    for (int r = 0; r < 3; r++) begin
      goto(cyc + 2);
      for (int i = 0; i < 12; i++)
        mem2[i] = (r == 1) ? 32'($urandom_range(0, 6)) - 32'd3 : $urandom;
      er = '0;
      for (int o = 0; o < 3; o++) er[o] = ref_pool(1'b1, o, 1'b1);
      launch(1'b1, t0);
      for (int j = 0; j < 12; j++) begin
        goto(t0 + 1 + 9 * (j / 4) + 2 * (j % 4));
        chk($sformatf("w6_addr_adr%0d", j), 32'(a2.bufferIn_adr), 32'(adr6[j]));
        goto(t0 + 2 + 9 * (j / 4) + 2 * (j % 4));
        chk($sformatf("w6_read_adr%0d", j), 32'(a2.bufferIn_adr), 32'(adr6[j]));
      end
      check_run(2, t0, 3, er);
    end

    goto(cyc + 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
